// File: rtl/divider_pkg.sv
// Shared definitions for the pipelined divider and its reconstruction multiplier.
package divider_pkg;

  localparam int unsigned DIVIDENDLEN_DEF = 16;
  localparam int unsigned DIVISORLEN_DEF  = 8;

  // Product / datapath width: quotient*divisor + remainder never exceeds this.
  function automatic int unsigned prodlen(input int unsigned dividendlen,
                                          input int unsigned divisorlen);
    return dividendlen + divisorlen;
  endfunction

  localparam int unsigned PRODLEN_DEF = prodlen(DIVIDENDLEN_DEF, DIVISORLEN_DEF);

  // One pipeline stage at the default widths.
  typedef struct packed {
    logic                       valid;
    logic [PRODLEN_DEF-1:0]     acc;
    logic [DIVISORLEN_DEF-1:0]  divisor;
    logic [DIVIDENDLEN_DEF-1:0] quotient;
    logic                       err;
  } stage_t;

endpackage

// File: rtl/remult_slice.sv
// One reconstruction step: add the shifted divisor when this stage's quotient bit is set.
module remult_slice import divider_pkg::*; #(
  parameter int unsigned SHIFT       = 0,
  parameter int unsigned DIVIDENDLEN = DIVIDENDLEN_DEF,
  parameter int unsigned DIVISORLEN  = DIVISORLEN_DEF
) (
  input  logic [prodlen(DIVIDENDLEN, DIVISORLEN)-1:0] acc_i,
  input  logic [DIVISORLEN-1:0]                       divisor_i,
  input  logic                                        qbit_i,
  output logic [prodlen(DIVIDENDLEN, DIVISORLEN)-1:0] acc_o
);

  localparam int unsigned PRODLEN = prodlen(DIVIDENDLEN, DIVISORLEN);

  logic [PRODLEN-1:0] addend;

  // Unsigned PRODLEN-wide add; the carry out can never be set for legal operands.
  always_comb begin
    addend = PRODLEN'(divisor_i) << SHIFT;
    acc_o  = qbit_i ? acc_i + addend : acc_i;
  end

endmodule

// File: rtl/pipelined_remult.sv
// Pipelined quotient*divisor + remainder, one quotient bit per stage, MSB first,
// with whole-pipeline backpressure.
module pipelined_remult import divider_pkg::*; #(
  parameter int unsigned DIVIDENDLEN = DIVIDENDLEN_DEF,
  parameter int unsigned DIVISORLEN  = DIVISORLEN_DEF
) (
  input  logic                                        clock,
  input  logic                                        reset,
  input  logic                                        in_valid,
  output logic                                        in_ready,
  input  logic [DIVIDENDLEN-1:0]                      quotient,
  input  logic [DIVISORLEN-1:0]                       divisor,
  input  logic [DIVISORLEN-1:0]                       remainder,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic [prodlen(DIVIDENDLEN, DIVISORLEN)-1:0] product,
  output logic                                        err
);

  localparam int unsigned PRODLEN = prodlen(DIVIDENDLEN, DIVISORLEN);
  localparam int unsigned N       = DIVIDENDLEN;

  typedef struct packed {
    logic                   valid;
    logic [PRODLEN-1:0]     acc;
    logic [DIVISORLEN-1:0]  divisor;
    logic [DIVIDENDLEN-1:0] quotient;
    logic                   err;
  } rm_stage_t;

  rm_stage_t          stage_q [N];
  rm_stage_t          feed    [N];
  logic [PRODLEN-1:0] sum     [N];
  logic               stall;

  // Handshake: only a full, unaccepted last stage blocks the pipe.
  always_comb begin
    stall     = stage_q[N-1].valid && !out_ready;
    in_ready  = !stall;
    out_valid = stage_q[N-1].valid;
    product   = stage_q[N-1].acc;
    err       = stage_q[N-1].err;
  end

  // Stage inputs: slice 0 is fed from the operand ports, slice k from stage k-1.
  always_comb begin
    feed[0] = '{valid:    in_valid,
                acc:      PRODLEN'(remainder),
                divisor:  divisor,
                quotient: quotient,
                err:      (remainder >= divisor)};
    for (int k = 1; k < N; k++) begin
      feed[k] = stage_q[k-1];
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slice
    remult_slice #(
      .SHIFT       (N - 1 - k),
      .DIVIDENDLEN (DIVIDENDLEN),
      .DIVISORLEN  (DIVISORLEN)
    ) u_slice (
      .acc_i     (feed[k].acc),
      .divisor_i (feed[k].divisor),
      .qbit_i    (feed[k].quotient[N-1-k]),
      .acc_o     (sum[k])
    );
  end

  // Stage registers: all advance together unless stalled; data moves only with a valid item.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N; k++) begin
        stage_q[k] <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < N; k++) begin
        stage_q[k].valid <= feed[k].valid;
        if (feed[k].valid) begin
          stage_q[k].acc      <= sum[k];
          stage_q[k].divisor  <= feed[k].divisor;
          stage_q[k].quotient <= feed[k].quotient;
          stage_q[k].err      <= feed[k].err;
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_remult.sv
// Directed and scoreboarded checks for pipelined_remult.
module tb_pipelined_remult;

  localparam int unsigned N = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] quotient;
  logic [7:0]  divisor;
  logic [7:0]  remainder;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] product;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  int unsigned src_q[$], src_d[$], src_r[$], src_p[$], src_e[$];
  int unsigned sb_p[$], sb_e[$];

  pipelined_remult #(
    .DIVIDENDLEN (16),
    .DIVISORLEN  (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .quotient  (quotient),
    .divisor   (divisor),
    .remainder (remainder),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .err       (err)
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Single operand through an otherwise empty pipe, out_ready held high.
  task automatic run_single(input string tag, input logic [15:0] q, input logic [7:0] d,
                            input logic [7:0] r, input logic [23:0] exp_p, input logic exp_e);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    quotient  = q;
    divisor   = d;
    remainder = r;
    tick();
    in_valid = 1'b0;
    repeat (N - 2) tick();
    check({tag, "_early"}, out_valid, 1'b0);
    tick();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_product"}, product, exp_p);
    check({tag, "_err"}, err, exp_e);
    tick();
    check({tag, "_oneshot"}, out_valid, 1'b0);
  endtask

  // Streams the src_* queues back to back; optionally stalls the output once.
  task automatic run_stream(input string tag, input int stall_len);
    int  total;
    int  got;
    int  budget;
    int  stall_left;
    int  ir_low;
    bit  stalled_once;
    total        = src_q.size();
    got          = 0;
    budget       = 2 * total + 100;
    stall_left   = 0;
    ir_low       = 0;
    stalled_once = 0;
    while (got < total && budget > 0) begin
      if (stall_len > 0 && !stalled_once && out_valid) begin
        stalled_once = 1;
        stall_left   = stall_len;
      end
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (src_q.size() > 0) begin
        in_valid  = 1'b1;
        quotient  = 16'(src_q[0]);
        divisor   = 8'(src_d[0]);
        remainder = 8'(src_r[0]);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      check({tag, "_in_ready"}, in_ready, (stall_left > 0) ? 1'b0 : 1'b1);
      if (!in_ready) ir_low++;
      if (out_valid && out_ready) begin
        if (sb_p.size() == 0) begin
          check({tag, "_unexpected_out"}, 1'b1, 1'b0);
        end else begin
          check({tag, "_product"}, product, sb_p[0]);
          check({tag, "_err"}, err, sb_e[0]);
          void'(sb_p.pop_front());
          void'(sb_e.pop_front());
        end
        got++;
      end
      if (in_valid && in_ready) begin
        sb_p.push_back(src_p.pop_front());
        sb_e.push_back(src_e.pop_front());
        void'(src_q.pop_front());
        void'(src_d.pop_front());
        void'(src_r.pop_front());
      end
      tick();
      if (stall_left > 0) stall_left--;
      budget--;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({tag, "_count"}, got, total);
    check({tag, "_stall_cycles"}, ir_low, stall_len);
    repeat (3) begin
      tick();
      check({tag, "_no_dup"}, out_valid, 1'b0);
    end
  endtask

  initial begin
    int unsigned q, d, r, dd;
    int          stale;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    quotient  = '0;
    divisor   = '0;
    remainder = '0;
    tick();
    tick();
    reset = 1'b0;

    check("reset_out_valid", out_valid, 1'b0);
    check("reset_product", product, 24'h0);
    check("reset_err", err, 1'b0);
    check("reset_in_ready", in_ready, 1'b1);

    run_single("basic", 16'h1234, 8'h56, 8'h12, 24'h061D8A, 1'b0);
    run_single("maxval", 16'hFFFF, 8'hFF, 8'hFE, 24'hFEFFFF, 1'b0);
    run_single("rem_eq_div", 16'h0003, 8'h10, 8'h10, 24'h000040, 1'b1);
    run_single("div_zero", 16'hABCD, 8'h00, 8'h00, 24'h000000, 1'b1);

    // 20 random legal operands with a 5-cycle output stall.
    for (int i = 0; i < 20; i++) begin
      d = $urandom_range(1, 255);
      r = $urandom_range(0, d - 1);
      q = $urandom_range(0, 65535);
      src_q.push_back(q);
      src_d.push_back(d);
      src_r.push_back(r);
      src_p.push_back(q * d + r);
      src_e.push_back(0);
    end
    run_stream("stream", 5);

    // Fill 8 items, then reset: nothing may ever come out.
    out_ready = 1'b1;
    in_valid  = 1'b1;
    quotient  = 16'h0101;
    divisor   = 8'h22;
    remainder = 8'h01;
    repeat (8) tick();
    in_valid = 1'b0;
    reset    = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_out_valid", out_valid, 1'b0);
    check("rst_mid_product", product, 24'h0);
    check("rst_mid_in_ready", in_ready, 1'b1);
    out_ready = 1'b0;
    #1;
    check("empty_no_stall", in_ready, 1'b1);
    out_ready = 1'b1;
    stale = 0;
    repeat (2 * N) begin
      tick();
      if (out_valid) stale++;
    end
    check("rst_mid_stale", stale, 0);

    // Chained with a divider model: dividend / divisor reconstructs the dividend.
    for (int i = 0; i < 1000; i++) begin
      dd = $urandom_range(0, 65535);
      d  = $urandom_range(1, 255);
      src_q.push_back(dd / d);
      src_d.push_back(d);
      src_r.push_back(dd % d);
      src_p.push_back(dd);
      src_e.push_back(0);
    end
    run_stream("compose", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_remult.md
# pipelined_remult

Pipelined reconstruction multiplier: computes `quotient*divisor + remainder`, the inverse of the pipelined divider. It runs one quotient bit per stage, MSB first, with the same stage shift ordering as the divider so the two can be chained for self-check.
- Sits on the divider's output side in the datapath test harness and in any consumer that must verify or undo a division.
- Adds a valid/ready handshake with whole-pipeline backpressure.
- Flags malformed inputs where the remainder is not less than the divisor.

## Interface
- `DIVIDENDLEN`, 16, quotient width and pipeline depth (stages)
- `DIVISORLEN`, 8, divisor and remainder width
- derived `PRODLEN` = DIVIDENDLEN+DIVISORLEN, product width (never overflows: max = 2^PRODLEN − 2^DIVIDENDLEN)
- `clock`  in  1  single clock, all state on posedge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  input operands valid
- `in_ready`  out  1  block can accept this cycle
- `quotient`  in  DIVIDENDLEN  multiplier operand
- `divisor`  in  DIVISORLEN  multiplicand operand
- `remainder`  in  DIVISORLEN  addend, seeds the accumulator
- `out_valid`  out  1  product/err valid
- `out_ready`  in  1  consumer accepts this cycle
- `product`  out  PRODLEN  quotient*divisor + remainder
- `err`  out  1  remainder >= divisor (includes divisor==0), sampled at input

## Operation
- DIVIDENDLEN stage registers S[0..N-1], N = DIVIDENDLEN. Each holds:
  - valid bit
  - accumulator [PRODLEN-1:0]
  - divisor
  - quotient
  - err
- Stage k processes quotient bit SHIFT = N-1-k.
  - Next acc = acc + (divisor << SHIFT) if that bit is 1, else acc unchanged.
  - Adder is PRODLEN wide, unsigned, no carry out.
- Stage 0 input side: acc seed = zero-extended `remainder`; err = (remainder >= divisor), computed combinationally on input.
- Stall: `stall = S[N-1].valid && !out_ready`.
  - `in_ready = !stall`, combinational.
  - On stall, every stage register holds.
- No stall: all stages advance one position.
  - S[0].valid <= in_valid.
  - Data registers load only when the corresponding valid is 1; otherwise the previous contents are held.
- Bubbles are not compressed; an empty stage still moves one position per unstalled cycle.
- Outputs come straight from S[N-1]:
  - `out_valid` = S[N-1].valid
  - `product` = S[N-1].acc
  - `err` = S[N-1].err
- Transfer occurs when out_valid && out_ready. The next stage advances in the same edge.
- `err` does not suppress computation; the product is still reported.
- Ordering: strictly in-order, no reordering or drop.

## Timing
- Reset (synchronous): all valid bits 0, all data registers 0.
  - Out of reset: out_valid=0, product=0, err=0, in_ready=1.
- Latency: an operand accepted at edge t appears with out_valid=1 after edge t+N-1, i.e. N cycles in the pipeline. Default is 16.
- Throughput: one result per cycle while out_ready=1.
- in_valid high while in_ready low: the operand is not captured. The source must hold it.
- out_ready low while out_valid=0: no stall; the pipeline keeps filling.
- Reset mid-operation: all in-flight items are discarded on the reset edge, and nothing is emitted afterwards.
- Simultaneous output transfer and input accept in one cycle: both occur.

## Structure
- Shared package `divider_pkg`, also imported by pipelinediv-side code, holds:
  - stage struct typedef (valid, acc, divisor, quotient, err), parameterised via localparams
  - PRODLEN/DATAPATHLEN derivation function
- Sub-module `remult_slice #(SHIFT, DIVIDENDLEN, DIVISORLEN)`: combinational conditional shift-add for one stage.
- Top module: generates N slices and owns the stage registers, stall logic and handshake.

## Test plan
- quotient=0x1234, divisor=0x56, remainder=0x12, out_ready=1 -> after 16 cycles: product=0x061D8A, err=0, out_valid for exactly 1 cycle.
- quotient=0xFFFF, divisor=0xFF, remainder=0xFE -> product=0xFEFFFF, err=0 (max value, no overflow).
- divisor=0x10, remainder=0x10, quotient=0x0003 -> product=0x000040, err=1. Repeat with divisor=0x00, remainder=0x00, quotient=0xABCD -> product=0, err=1.
- Stream 20 random back-to-back operands and hold out_ready=0 for 5 cycles after the first out_valid. Required response:
  - in_ready=0 exactly during the stall
  - all 20 results arrive in order, all correct, none duplicated
- Fill 8 operands, then assert reset for 1 cycle. Required response:
  - the next cycle shows out_valid=0, product=0, in_ready=1
  - no stale result ever emerges
- Compose with pipelinediv: feed its quotient/remainder plus the original divisor here for 1000 random vectors (divisor≠0) -> product equals the original dividend and err=0 every time.
